// File: rtl/des_stream_scheduler.sv
// des_stream_scheduler: front end for the pipelined DES core.
// Two plaintext requesters share the core's single input port through a
// round-robin arbiter. An owner tag follows each block through the core, and
// ciphertext returns to its owner through a result FIFO. Blocks are issued
// only while the result FIFO has a free credit, because the core cannot stall.
// A key change waits for the pipeline to drain before des_key_o is updated.
`timescale 1ns/1ps
module des_stream_scheduler #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [63:0] KEY_RESET  = 64'h133457799BBCDFF1
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        req0_valid_i,
  input  logic [63:0] req0_data_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [63:0] req1_data_i,
  output logic        req1_ready_o,
  input  logic [63:0] key_in_i,
  input  logic        key_wr_i,
  output logic        key_busy_o,
  output logic [63:0] des_key_o,
  output logic [63:0] des_plaintext_o,
  output logic        des_iv_o,
  input  logic [63:0] des_ciphertext_i,
  input  logic        des_ov_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_data_o,
  output logic        rsp_id_o,
  input  logic        rsp_ready_i,
  output logic        err_ov_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_e;

  state_e          state_q;
  logic [63:0]     key_pend_q, des_key_q, des_pt_q;
  logic            key_busy_q, des_iv_q, last_q, err_ov_q;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   inflight_q, inflight_d;

  logic            tag_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   tag_wr_q, tag_rd_q;
  logic [CW-1:0]   tag_cnt_q, tag_cnt_d;

  logic [64:0]     res_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   res_wr_q, res_rd_q;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;

  logic            can_issue, grant0, grant1, req_hs, rsp_hs;
  logic            ov_ok, ov_bad;
  logic [64:0]     res_head;

  // Credit check: a pop in the same cycle as a full FIFO does not free a slot yet.
  assign can_issue    = (state_q == RUN) && (outstanding_q < CW'(FIFO_DEPTH));
  // last_q == 1 means requester 1 won last, so requester 0 has priority.
  assign grant0       = req0_valid_i & (~req1_valid_i | last_q);
  assign grant1       = req1_valid_i & (~req0_valid_i | ~last_q);
  assign req0_ready_o = grant0 & can_issue;
  assign req1_ready_o = grant1 & can_issue;
  assign req_hs       = req0_ready_o | req1_ready_o;

  assign ov_ok        = des_ov_i & (tag_cnt_q != '0);
  assign ov_bad       = des_ov_i & (tag_cnt_q == '0);

  assign res_head     = res_mem_q[res_rd_q];
  assign rsp_valid_o  = (res_cnt_q != '0);
  assign rsp_data_o   = res_head[63:0];
  assign rsp_id_o     = res_head[64];
  assign rsp_hs       = rsp_valid_o & rsp_ready_i;

  assign key_busy_o      = key_busy_q;
  assign des_key_o       = des_key_q;
  assign des_plaintext_o = des_pt_q;
  assign des_iv_o        = des_iv_q;
  assign err_ov_o        = err_ov_q;

  // Next-state for the counters; simultaneous increment and decrement cancel.
  always_comb begin
    outstanding_d = outstanding_q;
    inflight_d    = inflight_q;
    tag_cnt_d     = tag_cnt_q;
    res_cnt_d     = res_cnt_q;
    if (req_hs && !rsp_hs) outstanding_d = outstanding_q + CW'(1);
    if (!req_hs && rsp_hs) outstanding_d = outstanding_q - CW'(1);
    if (req_hs && !ov_ok)  inflight_d    = inflight_q + CW'(1);
    if (!req_hs && ov_ok)  inflight_d    = inflight_q - CW'(1);
    if (req_hs && !ov_ok)  tag_cnt_d     = tag_cnt_q + CW'(1);
    if (!req_hs && ov_ok)  tag_cnt_d     = tag_cnt_q - CW'(1);
    if (ov_ok && !rsp_hs)  res_cnt_d     = res_cnt_q + CW'(1);
    if (!ov_ok && rsp_hs)  res_cnt_d     = res_cnt_q - CW'(1);
  end

  // Key-change FSM: RUN -> DRAIN (wait for empty pipeline) -> LOAD -> RUN.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= RUN;
      key_pend_q <= '0;
      des_key_q  <= KEY_RESET;
      key_busy_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (key_wr_i) begin
            key_pend_q <= key_in_i;
            state_q    <= DRAIN;
            key_busy_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (key_wr_i) key_pend_q <= key_in_i;
          if (inflight_q == '0) state_q <= LOAD;
        end
        LOAD: begin
          des_key_q  <= key_pend_q;
          state_q    <= RUN;
          key_busy_q <= 1'b0;
        end
        default: begin
          state_q    <= RUN;
          key_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Issue register toward the core and round-robin pointer update.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      des_iv_q <= 1'b0;
      des_pt_q <= '0;
      last_q   <= 1'b1;
    end else begin
      des_iv_q <= req_hs;
      if (req_hs) begin
        des_pt_q <= req1_ready_o ? req1_data_i : req0_data_i;
        last_q   <= req1_ready_o;
      end
    end
  end

  // Counters, FIFO pointers and the sticky spurious-output flag.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      outstanding_q <= '0;
      inflight_q    <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      tag_cnt_q     <= '0;
      res_wr_q      <= '0;
      res_rd_q      <= '0;
      res_cnt_q     <= '0;
      err_ov_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      inflight_q    <= inflight_d;
      tag_cnt_q     <= tag_cnt_d;
      res_cnt_q     <= res_cnt_d;
      if (req_hs) tag_wr_q <= tag_wr_q + AW'(1);
      if (ov_ok)  tag_rd_q <= tag_rd_q + AW'(1);
      if (ov_ok)  res_wr_q <= res_wr_q + AW'(1);
      if (rsp_hs) res_rd_q <= res_rd_q + AW'(1);
      if (ov_bad) err_ov_q <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock_i) begin
    if (req_hs) tag_mem_q[tag_wr_q] <= req1_ready_o;
    if (ov_ok)  res_mem_q[res_wr_q] <= {tag_mem_q[tag_rd_q], des_ciphertext_i};
  end

endmodule

// File: tb/tb_des_stream_scheduler.sv
// Testbench for des_stream_scheduler. It contains a fixed-latency model of the
// DES core and streaming requester models. A scoreboard queue holds the
// expected {owner, ciphertext} of every accepted block in acceptance order.
`timescale 1ns/1ps
module tb_des_stream_scheduler;

  localparam int          DEPTH = 8;
  localparam int          LAT   = 6;
  localparam logic [63:0] KEY0  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY1  = 64'h0E329232EA6D0D73;

  typedef struct {logic id; logic [63:0] pt; logic [63:0] ct;} vec_t;
  typedef struct packed {logic [63:0] pt; logic [63:0] ct;} item_t;
  typedef struct packed {logic id; logic [63:0] ct;} exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic [63:0] key_in = '0;
  logic        key_wr = 1'b0;
  logic        key_busy;
  logic [63:0] des_key, des_pt;
  logic        des_iv;
  logic [63:0] des_ct = '0;
  logic        des_ov = 1'b0;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_id;
  logic        rsp_ready = 1'b0;
  logic        err_ov;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  des_stream_scheduler #(.FIFO_DEPTH(DEPTH), .KEY_RESET(KEY0)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_ready_o(req1_ready),
    .key_in_i(key_in), .key_wr_i(key_wr), .key_busy_o(key_busy),
    .des_key_o(des_key), .des_plaintext_o(des_pt), .des_iv_o(des_iv),
    .des_ciphertext_i(des_ct), .des_ov_i(des_ov),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_id_o(rsp_id),
    .rsp_ready_i(rsp_ready), .err_ov_o(err_ov)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core model: known DES answers under the reset key, a keyed mix otherwise.
  function automatic logic [63:0] core_f(input logic [63:0] pt, input logic [63:0] key);
    if (key == KEY0) begin
      case (pt)
        64'h496E206F6C64656E: return 64'hF095CDC9B8A0AD83;
        64'h2074696D65732077: return 64'h4109113BAD212ADE;
        64'h68656E2077697368: return 64'h7ECF0E52ADD999DE;
        default: ;
      endcase
    end
    return pt ^ {key[31:0], key[63:32]} ^ 64'h0F1E2D3C4B5A6978;
  endfunction

  // Fixed-latency pipelined core; it has no reset, so blocks in flight survive a scheduler reset.
  logic        pv [LAT];
  logic [63:0] pd [LAT];
  logic [63:0] pk [LAT];
  initial for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; pk[i] = '0; end
  always @(posedge clk) begin
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1]; pd[i] = pd[i-1]; pk[i] = pk[i-1];
    end
    pv[0] = des_iv; pd[0] = des_pt; pk[0] = des_key;
    des_ov = pv[LAT-1];
    des_ct = pv[LAT-1] ? core_f(pd[LAT-1], pk[LAT-1]) : 64'h0;
  end

  // Streaming requesters: present the queue head and advance after a handshake.
  item_t src0[$], src1[$];
  logic  hs0_f = 1'b0, hs1_f = 1'b0;
  always @(posedge clk) begin
    #1;
    if (hs0_f && src0.size() > 0) src0.delete(0);
    if (hs1_f && src1.size() > 0) src1.delete(0);
    hs0_f = 1'b0;
    hs1_f = 1'b0;
    req0_valid = (src0.size() > 0);
    req0_data  = (src0.size() > 0) ? src0[0].pt : 64'h0;
    req1_valid = (src1.size() > 0);
    req1_data  = (src1.size() > 0) ? src1[0].pt : 64'h0;
  end

  // Monitor: push the expected result on each accepted block and check each popped result.
  exp_t sb[$], rsp_log[$];
  int   grants[$];
  int   hs_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready || req1_ready) chk("ready_excl", 64'(req0_ready & req1_ready), 64'd0);
      if (req0_valid && req0_ready) begin
        sb.push_back('{id: 1'b0, ct: src0[0].ct});
        grants.push_back(0);
        hs_cnt++;
        hs0_f = 1'b1;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{id: 1'b1, ct: src1[0].ct});
        grants.push_back(1);
        hs_cnt++;
        hs1_f = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        exp_t e;
        rsp_log.push_back('{id: rsp_id, ct: rsp_data});
        chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("[TB] rsp id=%0d data=%h (expected id=%0d data=%h)", rsp_id, rsp_data, e.id, e.ct);
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_data", rsp_data, e.ct);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || src0.size() != 0 || src1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(sb.size() + src0.size() + src1.size()), 64'd0);
    chk({name, "_rspv"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[3];
    logic [63:0] model_key;
    int          base, n, seen, bad;

    tbl[0] = '{id: 1'b0, pt: 64'h496E206F6C64656E, ct: 64'hF095CDC9B8A0AD83};
    tbl[1] = '{id: 1'b0, pt: 64'h2074696D65732077, ct: 64'h4109113BAD212ADE};
    tbl[2] = '{id: 1'b1, pt: 64'h68656E2077697368, ct: 64'h7ECF0E52ADD999DE};
    model_key = KEY0;

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_des_iv", 64'(des_iv), 64'd0);
    chk("rst_des_pt", des_pt, 64'd0);
    chk("rst_des_key", des_key, KEY0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_key_busy", 64'(key_busy), 64'd0);
    chk("rst_err_ov", 64'(err_ov), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T2: both requesters streaming; grants alternate starting with requester 0.
    rsp_ready = 1'b1;
    tick();
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      src0.push_back('{pt: 64'h0A00 + 64'(i), ct: core_f(64'h0A00 + 64'(i), model_key)});
      src1.push_back('{pt: 64'h0B00 + 64'(i), ct: core_f(64'h0B00 + 64'(i), model_key)});
    end
    wait_idle("t2_idle", 200);
    chk("t2_grant_count", 64'(grants.size()), 64'd8);
    for (int i = 0; i < grants.size() && i < 8; i++)
      chk($sformatf("t2_grant%0d", i), 64'(grants[i]), 64'(i % 2));

    // T1: table vectors from requester 0, answers in issue order.
    tick();
    rsp_log.delete();
    for (int i = 0; i < 2; i++) src0.push_back('{pt: tbl[i].pt, ct: tbl[i].ct});
    wait_idle("t1_idle", 200);
    chk("t1_rsp_count", 64'(rsp_log.size()), 64'd2);
    for (int i = 0; i < 2 && i < rsp_log.size(); i++) begin
      chk($sformatf("t1_data%0d", i), rsp_log[i].ct, tbl[i].ct);
      chk($sformatf("t1_id%0d", i), 64'(rsp_log[i].id), 64'(tbl[i].id));
    end

    // T6: requester 1 alone; result visible the cycle after des_ov.
    tick();
    src1.push_back('{pt: tbl[2].pt, ct: tbl[2].ct});
    n = 0;
    do begin @(negedge clk); n++; end while (!des_ov && n < 50);
    chk("t6_ov_seen", 64'(des_ov), 64'd1);
    chk("t6_rspv_during_ov", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("t6_rspv_after_ov", 64'(rsp_valid), 64'd1);
    chk("t6_rsp_id", 64'(rsp_id), 64'd1);
    chk("t6_rsp_data", rsp_data, tbl[2].ct);
    wait_idle("t6_idle", 100);

    // T3: consumer stalled; issue stops at the credit limit, then resumes one per pop.
    tick();
    rsp_ready = 1'b0;
    base = hs_cnt;
    for (int i = 0; i < 12; i++)
      src0.push_back('{pt: 64'h3300 + 64'(i), ct: core_f(64'h3300 + 64'(i), model_key)});
    repeat (30) @(negedge clk);
    chk("t3_hs_at_limit", 64'(hs_cnt - base), 64'(DEPTH));
    chk("t3_ready_low", 64'(req0_ready), 64'd0);
    chk("t3_rspv", 64'(rsp_valid), 64'd1);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_no_grant_on_pop", 64'(req0_ready), 64'd0);
    @(negedge clk);
    chk("t3_credit_return", 64'(req0_ready), 64'd1);
    wait_idle("t3_idle", 300);
    chk("t3_hs_total", 64'(hs_cnt - base), 64'd12);

    // T4: key change with three blocks in flight.
    tick();
    base = hs_cnt;
    for (int i = 0; i < 3; i++)
      src0.push_back('{pt: 64'h4400 + 64'(i), ct: core_f(64'h4400 + 64'(i), model_key)});
    n = 0;
    while (hs_cnt - base < 3 && n < 50) begin @(negedge clk); n++; end
    tick();
    key_in = KEY1;
    key_wr = 1'b1;
    tick();
    key_wr = 1'b0;
    model_key = KEY1;
    src0.push_back('{pt: 64'h44FF, ct: core_f(64'h44FF, model_key)});
    seen = 0;
    bad = 0;
    n = 0;
    while (seen < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (des_ov) seen++;
      if (req0_ready || !key_busy) bad++;
    end
    chk("t4_ov_count", 64'(seen), 64'd3);
    chk("t4_drain_blocked", 64'(bad), 64'd0);
    chk("t4_no_hs_in_drain", 64'(hs_cnt - base), 64'd3);
    chk("t4_key_old", des_key, KEY0);
    n = 0;
    while (key_busy && n < 20) begin @(negedge clk); n++; end
    chk("t4_load_latency", 64'(n), 64'd3);
    chk("t4_busy_clear", 64'(key_busy), 64'd0);
    chk("t4_key_new", des_key, KEY1);
    wait_idle("t4_idle", 100);

    // T5: asynchronous reset mid-stream, then stale core outputs flag err_ov.
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      src0.push_back('{pt: 64'h5500 + 64'(i), ct: core_f(64'h5500 + 64'(i), model_key)});
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 60);
    chk("t5_pre_rspv", 64'(rsp_valid), 64'd1);
    chk("t5_pre_iv", 64'(des_iv), 64'd1);
    #1;
    rst_n = 1'b0;
    src0.delete();
    src1.delete();
    sb.delete();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("t5_async_iv", 64'(des_iv), 64'd0);
    chk("t5_async_pt", des_pt, 64'd0);
    chk("t5_async_rspv", 64'(rsp_valid), 64'd0);
    chk("t5_async_key", des_key, KEY0);
    chk("t5_async_busy", 64'(key_busy), 64'd0);
    chk("t5_async_err", 64'(err_ov), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!err_ov && n < 20) begin @(negedge clk); n++; end
    chk("t5_err_ov_set", 64'(err_ov), 64'd1);
    chk("t5_dropped", 64'(rsp_valid), 64'd0);
    repeat (10) @(negedge clk);
    chk("t5_err_ov_sticky", 64'(err_ov), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
